eu_loadstore_arbiter: RTL and testbench
=======================================

// Module: eu_loadstore_arbiter
// PURPOSE
//  Shares one external memory port among the VLIW core's execution units (eu0..eu2).
//  Each cycle it collects the per-EU load/store requests into a bundle, then serves them
//  one at a time, round-robin, over a req/ack memory handshake.
//  Load results are lane-extracted, extended and returned on a register writeback port.
//  stall holds the VLIW issue stage until the whole bundle has been served.
// PARAMETERS
//  NUM_EU     3   number of requesting execution units
//  REG_IDX_W  6   register index width (64 registers)
// PORTS
//  wb_clk_i      in   1           system clock
//  rst           in   1           asynchronous reset, active-high
//  req_valid     in   NUM_EU      per-EU request pending (is_load|is_store)
//  req_is_store  in   NUM_EU      1=store, 0=load
//  req_addr      in   NUM_EU*32   byte address, EU i at [32*i+:32]
//  req_size      in   NUM_EU*2    0=byte 1=half 2/3=word
//  req_sign_ext  in   NUM_EU      sign-extend load result
//  req_dest      in   NUM_EU*REG_IDX_W  load destination register
//  req_wdata     in   NUM_EU*32   store data, right-aligned
//  req_grant     out  NUM_EU      one-hot, 1-cycle pulse: EU i's request is complete
//  stall         out  1           core must hold issue
//  mem_req       out  1           memory request valid
//  mem_we        out  1           store
//  mem_addr      out  32          word-aligned address ({addr[31:2],2'b00})
//  mem_sel       out  4           byte-lane enables
//  mem_wdata     out  32          lane-replicated store data
//  mem_ack       in   1           memory completes the current request
//  mem_rdata     in   32          aligned read word, valid with mem_ack
//  wb_valid      out  1           load writeback strobe (1 cycle)
//  wb_idx        out  REG_IDX_W   writeback register
//  wb_val        out  32          writeback value
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, rr_ptr=0. All outputs 0; stall is combinational (see below).
//  stall = (state!=IDLE) | (|req_valid).
//  FSM states:
//   IDLE: if |req_valid, latch pending<=req_valid and go to SELECT.
//     Requests arriving outside IDLE are not latched.
//   SELECT: idx = first set bit of pending, searching from rr_ptr upward with wrap.
//     Register mem_* from the live inputs of EU idx; mem_req<=1; go to WAIT.
//   WAIT: mem_* held stable while mem_ack=0. mem_ack is ignored outside WAIT.
//     On mem_ack: mem_req<=0; pending[idx]<=0; req_grant[idx]<=1 for one cycle;
//     rr_ptr<=(idx+1) mod NUM_EU.
//     For loads also: wb_valid<=1, wb_idx<=dest, wb_val<=extracted value.
//     Next state: SELECT if other pending bits remain, else IDLE.
//  EUs hold their request fields stable until their grant.
//  Latency: a lone request in IDLE at cycle 0 with mem_ack=1 at cycle 2 gives grant and
//   wb at cycle 3. Each further bundle member adds 2 cycles plus its ack wait.
//  Lanes, with a=addr[1:0]:
//   byte: sel=1<<a; wdata={4{d[7:0]}}; load value=rdata[8a+:8].
//   half: sel=a[1]?1100:0011; wdata={2{d[15:0]}}; load value=rdata[16*a[1]+:16].
//   word: sel=1111; load value=rdata.
//   Unaligned low bits below the access size are ignored.
//  Extension: zero-extend, or sign-extend if req_sign_ext. Word loads are unchanged.
//  Stores produce no wb_valid.
//  Reset mid-operation: mem_req drops immediately and pending is cleared.
//   A late mem_ack after reset is ignored; no grant or wb is produced.
// TESTING
//  1 Load byte signed, EU1, addr 0x103; rdata 0x80123456 -> mem_sel 1000, wb_val 0xFFFFFF80,
//    grant 010, wb at cycle 3.
//  2 Store half, EU0, addr 0x2, wdata 0xAAAA1234 -> mem_sel 1100, mem_wdata 0x12341234,
//    mem_we 1, no wb_valid.
//  3 Round-robin: bundle {0} is served (rr_ptr becomes 1); next bundle {0,2} -> served in
//    order 2 then 0; stall stays high until the last grant.
//  4 Ack stretch: hold mem_ack low 5 cycles -> mem_req/addr/sel/wdata constant throughout,
//    stall=1, no grant.
//  5 Reset asserted in WAIT, then mem_ack pulses -> mem_req=0 at once, no grant, no wb;
//    a new req_valid is served normally afterwards.
//  6 Three loads, unsigned half at addr 0x2, rdata 0xBEEF0000 ->
//    wb_val 0x0000BEEF per EU, wb_idx matches each req_dest.

Source files
------------

// File: rtl/eu_loadstore_arbiter.sv
// Shares one memory port among the execution units: latches a request bundle, then
// serves each member round-robin over a req/ack handshake, returning load data to the regfile.
module eu_loadstore_arbiter #(
    parameter int NUM_EU    = 3,
    parameter int REG_IDX_W = 6
) (
    input  logic                        wb_clk_i,
    input  logic                        rst,
    input  logic [NUM_EU-1:0]           req_valid,
    input  logic [NUM_EU-1:0]           req_is_store,
    input  logic [NUM_EU*32-1:0]        req_addr,
    input  logic [NUM_EU*2-1:0]         req_size,
    input  logic [NUM_EU-1:0]           req_sign_ext,
    input  logic [NUM_EU*REG_IDX_W-1:0] req_dest,
    input  logic [NUM_EU*32-1:0]        req_wdata,
    output logic [NUM_EU-1:0]           req_grant,
    output logic                        stall,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [3:0]                  mem_sel,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata,
    output logic                        wb_valid,
    output logic [REG_IDX_W-1:0]        wb_idx,
    output logic [31:0]                 wb_val
);

    localparam int PTR_W = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

    typedef enum logic [1:0] {IDLE, SELECT, WAIT} state_t;

    state_t                 state_q;
    logic [NUM_EU-1:0]      pending_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       idx_q;
    logic [1:0]             ld_size_q;
    logic [1:0]             ld_lane_q;
    logic                   ld_sext_q;
    logic [REG_IDX_W-1:0]   ld_dest_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [31:0]            mem_addr_q;
    logic [3:0]             mem_sel_q;
    logic [31:0]            mem_wdata_q;
    logic [NUM_EU-1:0]      req_grant_q;
    logic                   wb_valid_q;
    logic [REG_IDX_W-1:0]   wb_idx_q;
    logic [31:0]            wb_val_q;

    logic [PTR_W-1:0]       pick_idx;
    int                     cand;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_data;
    logic [1:0]             sel_size;
    logic [3:0]             sel_mask;
    logic [31:0]            sel_lanes;
    logic [NUM_EU-1:0]      grant_onehot;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic [31:0]            ld_val;

    assign stall = (state_q != IDLE) | (|req_valid);

    // Scan downward so the pending EU closest above rr_ptr is the one left standing.
    always_comb begin
        pick_idx = rr_ptr_q;
        cand     = 0;
        for (int k = NUM_EU - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr_q) + k) % NUM_EU;
            if (pending_q[cand]) pick_idx = PTR_W'(cand);
        end
    end

    assign sel_addr = req_addr[32*pick_idx +: 32];
    assign sel_data = req_wdata[32*pick_idx +: 32];
    assign sel_size = req_size[2*pick_idx +: 2];

    always_comb begin
        sel_mask  = 4'b1111;
        sel_lanes = sel_data;
        case (sel_size)
            2'd0: begin
                sel_mask  = 4'b0001 << sel_addr[1:0];
                sel_lanes = {4{sel_data[7:0]}};
            end
            2'd1: begin
                sel_mask  = sel_addr[1] ? 4'b1100 : 4'b0011;
                sel_lanes = {2{sel_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign grant_onehot = NUM_EU'(1) << idx_q;
    assign byte_v       = mem_rdata[8*ld_lane_q +: 8];
    assign half_v       = mem_rdata[16*ld_lane_q[1] +: 16];

    always_comb begin
        case (ld_size_q)
            2'd0:    ld_val = {{24{ld_sext_q & byte_v[7]}}, byte_v};
            2'd1:    ld_val = {{16{ld_sext_q & half_v[15]}}, half_v};
            default: ld_val = mem_rdata;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            ld_size_q   <= '0;
            ld_lane_q   <= '0;
            ld_sext_q   <= 1'b0;
            ld_dest_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
            req_grant_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_val_q    <= '0;
        end else begin
            req_grant_q <= '0;
            wb_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        pending_q <= req_valid;
                        state_q   <= SELECT;
                    end
                end
                SELECT: begin
                    idx_q       <= pick_idx;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= req_is_store[pick_idx];
                    mem_addr_q  <= {sel_addr[31:2], 2'b00};
                    mem_sel_q   <= sel_mask;
                    mem_wdata_q <= sel_lanes;
                    ld_size_q   <= sel_size;
                    ld_lane_q   <= sel_addr[1:0];
                    ld_sext_q   <= req_sign_ext[pick_idx];
                    ld_dest_q   <= req_dest[REG_IDX_W*pick_idx +: REG_IDX_W];
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        pending_q   <= pending_q & ~grant_onehot;
                        req_grant_q <= grant_onehot;
                        rr_ptr_q    <= (idx_q == PTR_W'(NUM_EU - 1)) ? '0 : idx_q + 1'b1;
                        if (!mem_we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_idx_q   <= ld_dest_q;
                            wb_val_q   <= ld_val;
                        end
                        state_q <= |(pending_q & ~grant_onehot) ? SELECT : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_sel   = mem_sel_q;
    assign mem_wdata = mem_wdata_q;
    assign req_grant = req_grant_q;
    assign wb_valid  = wb_valid_q;
    assign wb_idx    = wb_idx_q;
    assign wb_val    = wb_val_q;

endmodule

// File: tb/tb_eu_loadstore_arbiter.sv
// Bench for eu_loadstore_arbiter: a transaction-level model predicts the service order and
// every memory access / writeback; directed bundles exercise lanes, round-robin, stretch and reset.
module tb_eu_loadstore_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  reqValid = '0;
    logic [2:0]  reqIsStore = '0;
    logic [95:0] reqAddr = '0;
    logic [5:0]  reqSize = '0;
    logic [2:0]  reqSignExt = '0;
    logic [17:0] reqDest = '0;
    logic [95:0] reqWdata = '0;
    logic [2:0]  reqGrant;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memSel;
    logic [31:0] memWdata;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;
    logic        wbValid;
    logic [5:0]  wbIdx;
    logic [31:0] wbVal;

    eu_loadstore_arbiter #(.NUM_EU(3), .REG_IDX_W(6)) dut (
        .wb_clk_i(clock), .rst(reset),
        .req_valid(reqValid), .req_is_store(reqIsStore), .req_addr(reqAddr),
        .req_size(reqSize), .req_sign_ext(reqSignExt), .req_dest(reqDest),
        .req_wdata(reqWdata), .req_grant(reqGrant), .stall(stall),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_sel(memSel),
        .mem_wdata(memWdata), .mem_ack(memAck), .mem_rdata(memRdata),
        .wb_valid(wbValid), .wb_idx(wbIdx), .wb_val(wbVal)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          eu;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        wb;
        logic [5:0]  wbIdx;
        logic [31:0] wbVal;
    } exp_t;

    exp_t        expQ[$];
    exp_t        head;
    int          modelRr = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    bit          ackAtEdge = 1'b0;

    bit          euStore[3];
    logic [31:0] euAddr[3];
    logic [1:0]  euSize[3];
    bit          euSext[3];
    logic [5:0]  euDest[3];
    logic [31:0] euWdata[3];

    int          firstGrantCycle;
    int          grantOrder[$];
    int          wbCount = 0;
    logic [31:0] lastWbVal = '0;
    logic [5:0]  lastWbIdx = '0;
    logic [2:0]  lastGrant = '0;
    logic [3:0]  lastSel = '0;
    logic [31:0] lastWdata = '0;
    logic        lastWe = 1'b0;
    logic [31:0] lastAddr = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] expSel(input logic [31:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return 4'(32'd1 << (32'(a[1:0])));
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expWdata(input logic [31:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] expLoad(input logic [31:0] rd, input logic [31:0] a,
                                            input logic [1:0] s, input bit sx);
        logic [31:0] v;
        case (s)
            2'd0: begin
                v = (rd >> (8 * 32'(a[1:0]))) & 32'h0000_00FF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (rd >> (16 * 32'(a[1]))) & 32'h0000_FFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Tracks whether the memory handshake completed at the edge that just passed.
    always @(posedge clock or posedge reset) begin
        if (reset) ackAtEdge <= 1'b0;
        else       ackAtEdge <= memReq && memAck;
    end

    // Single compare process: every cycle, DUT outputs against the head of the expected queue.
    always @(negedge clock) begin
        if (!reset) begin
            if ((reqGrant != 0) || ackAtEdge)
                checkOutput("grant follows ack", 32'(reqGrant != 0), 32'(ackAtEdge));
            if (reqGrant != 0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected grant", 32'(reqGrant), 32'd0);
                end else begin
                    head = expQ.pop_front();
                    checkOutput("grant eu", 32'(reqGrant), 32'd1 << head.eu);
                    checkOutput("wb_valid", 32'(wbValid), 32'(head.wb));
                    if (head.wb) begin
                        checkOutput("wb_idx", 32'(wbIdx), 32'(head.wbIdx));
                        checkOutput("wb_val", wbVal, head.wbVal);
                    end
                end
                lastGrant = reqGrant;
            end else if (wbValid) begin
                checkOutput("stray wb_valid", 32'(wbValid), 32'd0);
            end
            if (wbValid) begin
                wbCount++;
                lastWbVal = wbVal;
                lastWbIdx = wbIdx;
            end
            if (memReq) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected mem_req", 32'(memReq), 32'd0);
                end else begin
                    checkOutput("mem_we", 32'(memWe), 32'(expQ[0].we));
                    checkOutput("mem_addr", memAddr, expQ[0].addr);
                    checkOutput("mem_sel", 32'(memSel), 32'(expQ[0].sel));
                    if (expQ[0].we) checkOutput("mem_wdata", memWdata, expQ[0].wdata);
                end
                checkOutput("stall during access", 32'(stall), 32'd1);
                lastSel   = memSel;
                lastWdata = memWdata;
                lastWe    = memWe;
                lastAddr  = memAddr;
            end
        end
    end

    task automatic setEu(input int i, input bit st, input logic [31:0] a, input logic [1:0] sz,
                         input bit sx, input logic [5:0] d, input logic [31:0] wd);
        euStore[i] = st; euAddr[i] = a; euSize[i] = sz;
        euSext[i] = sx; euDest[i] = d; euWdata[i] = wd;
        reqIsStore[i]         = st;
        reqAddr[32*i +: 32]   = a;
        reqSize[2*i +: 2]     = sz;
        reqSignExt[i]         = sx;
        reqDest[6*i +: 6]     = d;
        reqWdata[32*i +: 32]  = wd;
    endtask

    // A static bundle is served in ascending EU order starting at the round-robin pointer.
    task automatic launchModel(input logic [2:0] mask, input logic [31:0] rd);
        int last;
        exp_t item;
        last = modelRr;
        for (int k = 0; k < 3; k++) begin
            int e;
            e = (modelRr + k) % 3;
            if (mask[e]) begin
                item.eu    = e;
                item.we    = euStore[e];
                item.addr  = {euAddr[e][31:2], 2'b00};
                item.sel   = expSel(euAddr[e], euSize[e]);
                item.wdata = expWdata(euWdata[e], euSize[e]);
                item.wb    = !euStore[e];
                item.wbIdx = euDest[e];
                item.wbVal = expLoad(rd, euAddr[e], euSize[e], euSext[e]);
                expQ.push_back(item);
                last = e;
            end
        end
        modelRr = (last + 1) % 3;
    endtask

    task automatic runBundle(input int ackDelay, input int budget);
        int waitCnt;
        bit done;
        waitCnt = 0;
        done = 1'b0;
        firstGrantCycle = -1;
        grantOrder.delete();
        for (int cyc = 1; cyc <= budget && !done; cyc++) begin
            @(negedge clock); #1;
            if (reqGrant != 0) begin
                if (firstGrantCycle < 0) firstGrantCycle = cyc;
                for (int i = 0; i < 3; i++) if (reqGrant[i]) grantOrder.push_back(i);
                reqValid = reqValid & ~reqGrant;
            end
            if (reqValid != 0) checkOutput("stall held", 32'(stall), 32'd1);
            if (memAck) begin
                memAck  = 1'b0;
                waitCnt = 0;
            end else if (memReq) begin
                if (waitCnt >= ackDelay) memAck = 1'b1;
                else waitCnt++;
            end
            if (reqValid == 0 && !memReq && !memAck) begin
                #1;
                checkOutput("stall released", 32'(stall), 32'd0);
                checkOutput("model drained", 32'(expQ.size()), 32'd0);
                done = 1'b1;
            end
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL bundle timeout: got valid=%b expected 000", reqValid);
            memAck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] mask, input logic [31:0] rd, input int ackDelay);
        @(negedge clock); #1;
        memRdata = rd;
        reqValid = mask;
        launchModel(mask, rd);
        runBundle(ackDelay, 60);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wbBefore;
        repeat (2) @(negedge clock);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset mem_req", 32'(memReq), 32'd0);
        checkOutput("reset grant", 32'(reqGrant), 32'd0);
        checkOutput("reset wb_valid", 32'(wbValid), 32'd0);
        checkOutput("reset mem_addr", memAddr, 32'd0);
        #1 reset = 1'b0;

        $display("[TB] test 1: signed byte load, EU1");
        setEu(1, 0, 32'h0000_0103, 2'd0, 1, 6'd12, 32'h0);
        applyStimulus(3'b010, 32'h8012_3456, 0);
        checkOutput("t1 grant cycle", 32'(firstGrantCycle), 32'd3);
        checkOutput("t1 grant", 32'(lastGrant), 32'b010);
        checkOutput("t1 mem_sel", 32'(lastSel), 32'b1000);
        checkOutput("t1 mem_addr", lastAddr, 32'h0000_0100);
        checkOutput("t1 wb_val", lastWbVal, 32'hFFFF_FF80);
        checkOutput("t1 wb_idx", 32'(lastWbIdx), 32'd12);

        $display("[TB] test 2: half store, EU0");
        wbBefore = wbCount;
        setEu(0, 1, 32'h0000_0002, 2'd1, 0, 6'd0, 32'hAAAA_1234);
        applyStimulus(3'b001, 32'h0, 0);
        checkOutput("t2 mem_sel", 32'(lastSel), 32'b1100);
        checkOutput("t2 mem_wdata", lastWdata, 32'h1234_1234);
        checkOutput("t2 mem_we", 32'(lastWe), 32'd1);
        checkOutput("t2 no wb", 32'(wbCount - wbBefore), 32'd0);

        $display("[TB] test 3: round-robin order");
        setEu(0, 1, 32'h0000_0011, 2'd0, 0, 6'd0, 32'h0000_005A);
        applyStimulus(3'b001, 32'h0, 0);
        checkOutput("t3 byte wdata", lastWdata, 32'h5A5A_5A5A);
        checkOutput("t3 byte sel", 32'(lastSel), 32'b0010);
        setEu(2, 0, 32'h0000_0208, 2'd2, 0, 6'd3, 32'h0);
        applyStimulus(3'b101, 32'hCAFE_F00D, 1);
        checkOutput("t3 grants", 32'(grantOrder.size()), 32'd2);
        if (grantOrder.size() == 2) begin
            checkOutput("t3 first", 32'(grantOrder[0]), 32'd2);
            checkOutput("t3 second", 32'(grantOrder[1]), 32'd0);
        end

        $display("[TB] test 4: ack stretch");
        setEu(2, 1, 32'h0000_030C, 2'd3, 0, 6'd0, 32'hDEAD_BEEF);
        applyStimulus(3'b100, 32'h0, 5);
        checkOutput("t4 grant cycle", 32'(firstGrantCycle), 32'd8);
        checkOutput("t4 wdata", lastWdata, 32'hDEAD_BEEF);

        $display("[TB] test 5: reset while waiting");
        setEu(1, 0, 32'h0000_0040, 2'd2, 0, 6'd9, 32'h0);
        @(negedge clock); #1;
        reqValid = 3'b010;
        launchModel(3'b010, 32'h1111_2222);
        for (int c = 0; c < 10 && !memReq; c++) begin
            @(negedge clock); #1;
        end
        checkOutput("t5 in wait", 32'(memReq), 32'd1);
        wbBefore = wbCount;
        reset = 1'b1;
        reqValid = '0;
        expQ.delete();
        modelRr = 0;
        #1;
        checkOutput("t5 mem_req drops", 32'(memReq), 32'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        memAck = 1'b1;
        @(negedge clock); #1;
        memAck = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("t5 no grant", 32'(reqGrant), 32'd0);
            checkOutput("t5 no wb", 32'(wbValid), 32'd0);
            @(negedge clock); #1;
        end
        checkOutput("t5 wb count", 32'(wbCount - wbBefore), 32'd0);
        setEu(2, 0, 32'h0000_0044, 2'd2, 0, 6'd21, 32'h0);
        applyStimulus(3'b100, 32'h1357_9BDF, 0);
        checkOutput("t5 recovered wb", lastWbVal, 32'h1357_9BDF);
        checkOutput("t5 recovered idx", 32'(lastWbIdx), 32'd21);

        $display("[TB] test 6: three unsigned half loads");
        wbBefore = wbCount;
        setEu(0, 0, 32'h0000_0002, 2'd1, 0, 6'd5, 32'h0);
        setEu(1, 0, 32'h0000_0002, 2'd1, 0, 6'd17, 32'h0);
        setEu(2, 0, 32'h0000_0002, 2'd1, 0, 6'd63, 32'h0);
        applyStimulus(3'b111, 32'hBEEF_0000, 0);
        checkOutput("t6 wb count", 32'(wbCount - wbBefore), 32'd3);
        checkOutput("t6 wb_val", lastWbVal, 32'h0000_BEEF);
        checkOutput("t6 last idx", 32'(lastWbIdx), 32'd63);
        checkOutput("t6 first grant cycle", 32'(firstGrantCycle), 32'd3);

        $display("[TB] test 7: mixed bundle");
        setEu(0, 0, 32'h0000_0001, 2'd0, 0, 6'd1, 32'h0);
        setEu(1, 0, 32'h0000_0006, 2'd1, 1, 6'd2, 32'h0);
        setEu(2, 1, 32'h0000_0007, 2'd0, 0, 6'd0, 32'h0000_0077);
        applyStimulus(3'b111, 32'h9ABC_5600, 2);
        checkOutput("t7 store sel", 32'(lastSel), 32'b1000);
        checkOutput("t7 store wdata", lastWdata, 32'h7777_7777);
        checkOutput("t7 signed half", lastWbVal, 32'hFFFF_9ABC);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
